cpu_control_fsm: RTL and testbench

Multi-cycle control sequencer for the RV32I core. Steps the fetch/decode/execute datapath through a fixed state sequence. Owns the single memory port's request/done handshake for instruction fetch, load and store. Drives the register-file read, write-back and PC-update enables, and stops the core on SYSTEM instructions or memory timeouts. Sits between the decoder flags and the datapath registers, PC, regfile and memory.

---
 rtl/cpu_control_fsm_if.sv | 11 +
 rtl/cpu_control_fsm.sv | 161 ++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_control_fsm_if.sv
// Memory-port handshake between the control sequencer (master) and memory (slave).
// addr_sel steers the shared address mux: 0 = PC, 1 = rs1+imm.
interface cpu_control_fsm_if;
    logic mem_rstrb;
    logic mem_wstrb;
    logic addr_sel;
    logic mem_done;

    modport master (output mem_rstrb, output mem_wstrb, output addr_sel, input mem_done);
    modport slave  (input mem_rstrb, input mem_wstrb, input addr_sel, output mem_done);
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle RV32I control sequencer: fetch/decode/execute stepping, memory handshake,
// regfile/PC enables, halt on SYSTEM or memory timeout, cycle and retired-instruction counters.
module cpu_control_fsm #(
    parameter int unsigned COUNTER_W = 32,
    parameter int unsigned TIMEOUT   = 0
) (
    input  logic                 clk,
    input  logic                 resetn,
    cpu_control_fsm_if.master    mem,
    input  logic                 i_is_load,
    input  logic                 i_is_store,
    input  logic                 i_is_sys,
    input  logic                 i_writes_rd,
    output logic                 o_instr_we,
    output logic                 o_rf_re,
    output logic                 o_wb_en,
    output logic                 o_pc_we,
    output logic [2:0]           o_state,
    output logic                 o_halted,
    output logic                 o_fault,
    output logic [COUNTER_W-1:0] o_cycles,
    output logic [COUNTER_W-1:0] o_instret
);

    localparam logic [2:0] FETCH_INSTR = 3'd0;
    localparam logic [2:0] WAIT_INSTR  = 3'd1;
    localparam logic [2:0] FETCH_REGS  = 3'd2;
    localparam logic [2:0] EXECUTE     = 3'd3;
    localparam logic [2:0] LOAD        = 3'd4;
    localparam logic [2:0] WAIT_DATA   = 3'd5;
    localparam logic [2:0] STORE       = 3'd6;
    localparam logic [2:0] HALT        = 3'd7;

    // r_wait holds completed wait cycles, so the current wait cycle is r_wait+1.
    localparam logic [15:0] LP_WAIT_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    logic [2:0]           r_state;
    logic                 r_halted;
    logic                 r_fault;
    logic [15:0]          r_wait;
    logic [COUNTER_W-1:0] r_cycles;
    logic [COUNTER_W-1:0] r_instret;

    logic [2:0] w_next;
    logic       w_rstrb, w_wstrb, w_addr_sel, w_instr_we, w_rf_re, w_wb_en, w_pc_we;
    logic       w_retire, w_fault_set, w_timeout, w_in_wait;

    assign w_timeout = (TIMEOUT != 0) && (r_wait == LP_WAIT_LAST);
    assign w_in_wait = (r_state == WAIT_INSTR) || (r_state == WAIT_DATA);

    always_comb begin
        w_next      = r_state;
        w_rstrb     = 1'b0;
        w_wstrb     = 1'b0;
        w_addr_sel  = 1'b0;
        w_instr_we  = 1'b0;
        w_rf_re     = 1'b0;
        w_wb_en     = 1'b0;
        w_pc_we     = 1'b0;
        w_retire    = 1'b0;
        w_fault_set = 1'b0;
        case (r_state)
            FETCH_INSTR: begin
                w_rstrb = 1'b1;
                w_next  = WAIT_INSTR;
            end
            WAIT_INSTR: begin
                if (mem.mem_done) begin
                    w_instr_we = 1'b1;
                    w_next     = FETCH_REGS;
                end else if (w_timeout) begin
                    w_fault_set = 1'b1;
                    w_next      = HALT;
                end
            end
            FETCH_REGS: begin
                w_rf_re = 1'b1;
                w_next  = EXECUTE;
            end
            EXECUTE: begin
                if (i_is_sys) begin
                    w_next = HALT;
                end else begin
                    w_pc_we = 1'b1;
                    if (i_is_load) begin
                        w_next = LOAD;
                    end else if (i_is_store) begin
                        w_next = STORE;
                    end else begin
                        w_wb_en  = i_writes_rd;
                        w_retire = 1'b1;
                        w_next   = FETCH_INSTR;
                    end
                end
            end
            LOAD: begin
                w_rstrb    = 1'b1;
                w_addr_sel = 1'b1;
                w_next     = WAIT_DATA;
            end
            STORE: begin
                w_wstrb    = 1'b1;
                w_addr_sel = 1'b1;
                w_next     = WAIT_DATA;
            end
            WAIT_DATA: begin
                w_addr_sel = 1'b1;
                if (mem.mem_done) begin
                    w_wb_en  = i_is_load;
                    w_retire = 1'b1;
                    w_next   = FETCH_INSTR;
                end else if (w_timeout) begin
                    w_fault_set = 1'b1;
                    w_next      = HALT;
                end
            end
            default: w_next = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= FETCH_INSTR;
            r_halted  <= 1'b0;
            r_fault   <= 1'b0;
            r_wait    <= '0;
            r_cycles  <= '0;
            r_instret <= '0;
        end else begin
            r_state  <= w_next;
            r_halted <= r_halted | (w_next == HALT);
            r_fault  <= r_fault | w_fault_set;
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (w_in_wait) begin
                r_wait <= r_wait + 16'd1;
            end
            if (r_state != HALT) begin
                r_cycles <= r_cycles + COUNTER_W'(1);
            end
            if (w_retire) begin
                r_instret <= r_instret + COUNTER_W'(1);
            end
        end
    end

    // Reset gates every strobe/enable so nothing escapes in the reset cycle itself.
    assign mem.mem_rstrb = resetn & w_rstrb;
    assign mem.mem_wstrb = resetn & w_wstrb;
    assign mem.addr_sel  = resetn & w_addr_sel;
    assign o_instr_we    = resetn & w_instr_we;
    assign o_rf_re       = resetn & w_rf_re;
    assign o_wb_en       = resetn & w_wb_en;
    assign o_pc_we       = resetn & w_pc_we;
    assign o_state       = r_state;
    assign o_halted      = r_halted;
    assign o_fault       = r_fault;
    assign o_cycles      = r_cycles;
    assign o_instret     = r_instret;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: directed vector table, hand sequences for
// timeout/reset corners, and randomized instruction streams against a trace-generating model.
module tb_cpu_control_fsm;

    localparam int S_FI = 0, S_WI = 1, S_FR = 2, S_EX = 3, S_LD = 4, S_WD = 5, S_ST = 6, S_HT = 7;
    // Enable vector bit order: {rstrb, wstrb, addr_sel, instr_we, rf_re, wb_en, pc_we}
    localparam int E_RS = 'b1000000, E_WS = 'b0100000, E_AS = 'b0010000, E_IW = 'b0001000;
    localparam int E_RF = 'b0000100, E_WB = 'b0000010, E_PC = 'b0000001;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_is_load, i_is_store, i_is_sys, i_writes_rd;
    logic        o_instr_we, o_rf_re, o_wb_en, o_pc_we, o_halted, o_fault;
    logic [2:0]  o_state;
    logic [31:0] o_cycles, o_instret;
    logic        z_instr_we, z_rf_re, z_wb_en, z_pc_we, z_halted, z_fault;
    logic [2:0]  z_state;
    logic [3:0]  z_cycles, z_instret;

    cpu_control_fsm_if m ();
    cpu_control_fsm_if m0 ();
    assign m0.mem_done = m.mem_done;

    cpu_control_fsm #(.COUNTER_W(32), .TIMEOUT(4)) u_dut (
        .clk(clk), .resetn(resetn), .mem(m),
        .i_is_load(i_is_load), .i_is_store(i_is_store), .i_is_sys(i_is_sys), .i_writes_rd(i_writes_rd),
        .o_instr_we(o_instr_we), .o_rf_re(o_rf_re), .o_wb_en(o_wb_en), .o_pc_we(o_pc_we),
        .o_state(o_state), .o_halted(o_halted), .o_fault(o_fault),
        .o_cycles(o_cycles), .o_instret(o_instret)
    );

    cpu_control_fsm #(.COUNTER_W(4), .TIMEOUT(0)) u_dut0 (
        .clk(clk), .resetn(resetn), .mem(m0),
        .i_is_load(i_is_load), .i_is_store(i_is_store), .i_is_sys(i_is_sys), .i_writes_rd(i_writes_rd),
        .o_instr_we(z_instr_we), .o_rf_re(z_rf_re), .o_wb_en(z_wb_en), .o_pc_we(z_pc_we),
        .o_state(z_state), .o_halted(z_halted), .o_fault(z_fault),
        .o_cycles(z_cycles), .o_instret(z_instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rn, ld, st, sy, wr, dn;
        int s, en, hl, ft;
        int unsigned cyc, ret;
    } vec_t;

    int          n_pass = 0;
    int          n_total = 0;
    vec_t        tbl [0:27];
    vec_t        q[$];
    int unsigned m_cyc, m_ret;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int en_act();
        return int'({m.mem_rstrb, m.mem_wstrb, m.addr_sel, o_instr_we, o_rf_re, o_wb_en, o_pc_we});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input string tag);
        resetn      = (v.rn != 0);
        i_is_load   = (v.ld != 0);
        i_is_store  = (v.st != 0);
        i_is_sys    = (v.sy != 0);
        i_writes_rd = (v.wr != 0);
        m.mem_done  = (v.dn != 0);
        @(negedge clk);
        chk({tag, " state"}, int'(o_state), v.s);
        chk({tag, " enables"}, en_act(), v.en);
        chk({tag, " halted"}, int'(o_halted), v.hl);
        chk({tag, " fault"}, int'(o_fault), v.ft);
        chk({tag, " cycles"}, int'(o_cycles), int'(v.cyc));
        chk({tag, " instret"}, int'(o_instret), int'(v.ret));
        tick();
    endtask

    function automatic int rb();
        return int'($urandom_range(0, 1));
    endfunction

    function automatic int pick_wait();
        return ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 6));
    endfunction

    function automatic void push(input int rn, ld, st, sy, wr, dn, s, en, hl, ft);
        q.push_back('{rn, ld, st, sy, wr, dn, s, en, hl, ft, m_cyc, m_ret});
    endfunction

    // Core stopped: counters frozen, mem_done ignored, then a reset cycle restarts everything.
    task automatic halt_rows(input int ft);
        for (int i = 0; i < 2; i++) push(1, rb(), rb(), rb(), rb(), rb(), S_HT, 0, 1, ft);
        push(0, rb(), rb(), rb(), rb(), rb(), S_HT, 0, 1, ft);
        m_cyc = 0;
        m_ret = 0;
    endtask

    // One instruction's expected trace, built from its kind and chosen memory wait lengths.
    task automatic gen_instr();
        int k, ld, st, sy, wr, d1, d2, n, dn;
        k  = int'($urandom_range(0, 9));
        sy = (k == 0);
        ld = (k >= 1 && k <= 3) || (sy != 0 && rb() != 0);
        st = (k == 4 || k == 5) || ((sy != 0 || ld != 0) && rb() != 0);
        wr = rb();
        d1 = pick_wait();
        d2 = pick_wait();
        push(1, rb(), rb(), rb(), rb(), rb(), S_FI, E_RS, 0, 0);
        m_cyc++;
        n = (d1 < 4) ? d1 : 4;
        for (int i = 1; i <= n; i++) begin
            dn = (i == d1);
            push(1, rb(), rb(), rb(), rb(), dn, S_WI, (dn != 0) ? E_IW : 0, 0, 0);
            m_cyc++;
        end
        if (d1 > 4) begin
            halt_rows(1);
            return;
        end
        push(1, ld, st, sy, wr, rb(), S_FR, E_RF, 0, 0);
        m_cyc++;
        if (sy != 0) begin
            push(1, ld, st, sy, wr, rb(), S_EX, 0, 0, 0);
            m_cyc++;
            halt_rows(0);
            return;
        end
        push(1, ld, st, sy, wr, rb(), S_EX, E_PC | ((ld == 0 && st == 0 && wr != 0) ? E_WB : 0), 0, 0);
        m_cyc++;
        if (ld == 0 && st == 0) begin
            m_ret++;
            return;
        end
        push(1, ld, st, sy, wr, rb(), (ld != 0) ? S_LD : S_ST, ((ld != 0) ? E_RS : E_WS) | E_AS, 0, 0);
        m_cyc++;
        n = (d2 < 4) ? d2 : 4;
        for (int i = 1; i <= n; i++) begin
            dn = (i == d2);
            push(1, ld, st, sy, wr, dn, S_WD, E_AS | ((dn != 0 && ld != 0) ? E_WB : 0), 0, 0);
            m_cyc++;
            if (dn != 0) m_ret++;
        end
        if (d2 > 4) halt_rows(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        rn ld st sy wr dn  state  enables       hl ft cyc ret
        tbl = '{
            '{0, 1, 1, 1, 1, 1, S_FI, 0,           0, 0, 0,  0},
            '{1, 0, 0, 0, 0, 0, S_FI, E_RS,        0, 0, 0,  0},
            '{1, 0, 0, 0, 0, 1, S_WI, E_IW,        0, 0, 1,  0},
            '{1, 0, 0, 0, 1, 0, S_FR, E_RF,        0, 0, 2,  0},
            '{1, 0, 0, 0, 1, 0, S_EX, E_WB | E_PC, 0, 0, 3,  0},
            '{1, 0, 0, 0, 0, 0, S_FI, E_RS,        0, 0, 4,  1},
            '{1, 0, 0, 0, 0, 1, S_WI, E_IW,        0, 0, 5,  1},
            '{1, 1, 0, 0, 1, 0, S_FR, E_RF,        0, 0, 6,  1},
            '{1, 1, 0, 0, 1, 0, S_EX, E_PC,        0, 0, 7,  1},
            '{1, 1, 0, 0, 1, 1, S_LD, E_RS | E_AS, 0, 0, 8,  1},
            '{1, 1, 0, 0, 1, 0, S_WD, E_AS,        0, 0, 9,  1},
            '{1, 1, 0, 0, 1, 0, S_WD, E_AS,        0, 0, 10, 1},
            '{1, 1, 0, 0, 1, 1, S_WD, E_AS | E_WB, 0, 0, 11, 1},
            '{1, 0, 0, 0, 0, 0, S_FI, E_RS,        0, 0, 12, 2},
            '{1, 0, 0, 0, 0, 1, S_WI, E_IW,        0, 0, 13, 2},
            '{1, 0, 1, 0, 1, 0, S_FR, E_RF,        0, 0, 14, 2},
            '{1, 0, 1, 0, 1, 1, S_EX, E_PC,        0, 0, 15, 2},
            '{1, 0, 1, 0, 1, 1, S_ST, E_WS | E_AS, 0, 0, 16, 2},
            '{1, 0, 1, 0, 1, 1, S_WD, E_AS,        0, 0, 17, 2},
            '{1, 0, 0, 0, 0, 0, S_FI, E_RS,        0, 0, 18, 3},
            '{1, 0, 0, 0, 0, 1, S_WI, E_IW,        0, 0, 19, 3},
            '{1, 1, 0, 1, 0, 0, S_FR, E_RF,        0, 0, 20, 3},
            '{1, 1, 1, 1, 1, 0, S_EX, 0,           0, 0, 21, 3},
            '{1, 0, 0, 0, 0, 1, S_HT, 0,           1, 0, 22, 3},
            '{1, 1, 1, 0, 1, 1, S_HT, 0,           1, 0, 22, 3},
            '{1, 0, 0, 0, 0, 0, S_HT, 0,           1, 0, 22, 3},
            '{0, 0, 0, 0, 0, 1, S_HT, 0,           1, 0, 22, 3},
            '{1, 0, 0, 0, 0, 0, S_FI, E_RS,        0, 0, 0,  0}
        };

        resetn = 1'b0;
        i_is_load = 1'b0; i_is_store = 1'b0; i_is_sys = 1'b0; i_writes_rd = 1'b0;
        m.mem_done = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 28; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Fetch timeout with no mem_done; the TIMEOUT=0 instance keeps waiting and its 4-bit cycle count wraps.
        resetn = 1'b0; m.mem_done = 1'b0; i_is_load = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("to_fetch state", int'(o_state), S_FI);
        tick();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("to_wait%0d state", i), int'(o_state), S_WI);
            chk($sformatf("to_wait%0d fault", i), int'(o_fault), 0);
            tick();
        end
        @(negedge clk);
        chk("to_halt state", int'(o_state), S_HT);
        chk("to_halt halted", int'(o_halted), 1);
        chk("to_halt fault", int'(o_fault), 1);
        chk("to_halt cycles", int'(o_cycles), 5);
        repeat (12) tick();
        @(negedge clk);
        chk("to_frozen cycles", int'(o_cycles), 5);
        chk("nto state", int'(z_state), S_WI);
        chk("nto halted", int'(z_halted), 0);
        chk("nto cycles wrap", int'(z_cycles), 1);

        // mem_done on the last allowed wait cycle is accepted.
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        repeat (4) tick();
        m.mem_done = 1'b1;
        @(negedge clk);
        chk("to_last state", int'(o_state), S_WI);
        chk("to_last instr_we", int'(o_instr_we), 1);
        tick();
        m.mem_done = 1'b0;
        @(negedge clk);
        chk("to_last next state", int'(o_state), S_FR);
        chk("to_last fault", int'(o_fault), 0);
        chk("to_last halted", int'(o_halted), 0);

        // Reset in WAIT_DATA with mem_done present: no write-back, clean restart.
        i_is_load = 1'b1;
        repeat (3) tick();
        resetn = 1'b0;
        m.mem_done = 1'b1;
        @(negedge clk);
        chk("rst_wd state", int'(o_state), S_WD);
        chk("rst_wd enables", en_act(), 0);
        tick();
        resetn = 1'b1;
        m.mem_done = 1'b0;
        i_is_load = 1'b0;
        @(negedge clk);
        chk("rst_rel state", int'(o_state), S_FI);
        chk("rst_rel cycles", int'(o_cycles), 0);
        chk("rst_rel instret", int'(o_instret), 0);
        chk("rst_rel enables", en_act(), E_RS);
        tick();

        // Randomized instruction stream.
        resetn = 1'b0;
        tick();
        m_cyc = 0;
        m_ret = 0;
        q.delete();
        repeat (60) gen_instr();
        foreach (q[i]) apply(q[i], $sformatf("rnd%0d", i));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
